mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one N-bit output channel between M requesters.

---
 rtl/mux_pkg.sv | 16 +
 rtl/Multiplexer_MxN.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_pkg : shared types and helpers for the mux/arbiter slice     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mux_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Select width for m inputs; a single input still needs a 1-bit select.
  function automatic int sel_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/Multiplexer_MxN.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Multiplexer_MxN : M-way N-bit mux over a flat bus {chM..ch1}     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module Multiplexer_MxN
  import mux_pkg::*;
#(
  parameter int M     = 8,
  parameter int N     = 5,
  parameter int SEL_W = sel_width(M)
) (
  input  logic [M*N-1:0] in_data,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]   out_data
);

  // Out-of-range selects (non-power-of-2 M) yield zero.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < M; i++) begin
      if (sel == SEL_W'(i)) begin
        out_data = in_data[i*N +: N];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mux_rr_arbiter : round-robin arbiter sharing one N-bit channel   |
// | between M requesters with a registered valid/ready output.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int M     = 8,
  parameter int N     = 5,
  parameter int SEL_W = sel_width(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     req,
  input  logic [M*N-1:0]   ch_data,
  output logic [M-1:0]     in_ack,
  output logic [M-1:0]     grant,
  output logic [SEL_W-1:0] select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data
);

  // First set bit of cand at or after ptr; the doubled vector handles wrap for any M.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [M-1:0] cand,
                                               input logic [SEL_W-1:0] ptr);
    logic [2*M-1:0] dbl;
    logic           found;
    rr_pick = '0;
    found   = 1'b0;
    dbl     = {cand, cand};
    for (int i = 0; i < 2*M; i++) begin
      if (!found && dbl[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        rr_pick = (i >= M) ? SEL_W'(i - M) : SEL_W'(i);
      end
    end
  endfunction

  arb_state_t       r_state;
  logic [SEL_W-1:0] r_prio_ptr;
  logic [M-1:0]     r_grant;
  logic [SEL_W-1:0] r_select;
  logic [N-1:0]     r_out_data;
  logic             r_out_valid;

  logic             w_hs;
  logic [SEL_W-1:0] w_ptr_next;
  logic [SEL_W-1:0] w_ptr;
  logic [M-1:0]     w_cand;
  logic [SEL_W-1:0] w_pick;
  logic [N-1:0]     w_mux_data;

  assign w_hs       = r_out_valid & out_ready;
  assign w_ptr_next = (r_select == SEL_W'(M - 1)) ? '0 : r_select + 1'b1;
  // On a handshake the re-arbitration already sees the rotated pointer.
  assign w_ptr      = w_hs ? w_ptr_next : r_prio_ptr;
  assign w_cand     = (r_state == ARB_IDLE) ? req : (req & ~r_grant);
  assign w_pick     = rr_pick(w_cand, w_ptr);

  Multiplexer_MxN #(
    .M     (M),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data  (ch_data),
    .sel      (w_pick),
    .out_data (w_mux_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_prio_ptr  <= '0;
      r_grant     <= '0;
      r_select    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_cand) begin
            r_grant     <= M'(1) << w_pick;
            r_select    <= w_pick;
            r_out_data  <= w_mux_data;
            r_out_valid <= 1'b1;
            r_state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_hs) begin
            r_prio_ptr <= w_ptr_next;
            if (|w_cand) begin
              r_grant    <= M'(1) << w_pick;
              r_select   <= w_pick;
              r_out_data <= w_mux_data;
            end else begin
              r_grant     <= '0;
              r_out_valid <= 1'b0;
              r_state     <= ARB_IDLE;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign in_ack    = w_hs ? r_grant : '0;
  assign grant     = r_grant;
  assign select    = r_select;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mux_rr_arbiter : scoreboard bench for mux_rr_arbiter          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mux_rr_arbiter;

  localparam int M     = 8;
  localparam int N     = 5;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [M-1:0]     req;
  logic [M*N-1:0]   ch_data;
  logic [M-1:0]     in_ack;
  logic [M-1:0]     grant;
  logic [SEL_W-1:0] select;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           ch;
    logic [N-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: which channel holds the output and where priority starts.
  bit m_busy = 1'b0;
  int m_ch   = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ch_data   (ch_data),
    .in_ack    (in_ack),
    .grant     (grant),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("ack_in_reset", 32'(in_ack), 32'h0);
    end else begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("select", 32'(select), 32'(exp_q[0].ch));
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("grant", 32'(grant), 32'(1) << exp_q[0].ch);
        check("in_ack", 32'(in_ack), out_ready ? (32'(1) << exp_q[0].ch) : 32'h0);
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        check("grant_idle", 32'(grant), 32'h0);
        check("in_ack_idle", 32'(in_ack), 32'h0);
      end
    end
  end

  // Model: decides the next transfer from the pick rule and pushes it.
  always @(negedge clk) begin
    logic [M-1:0] cand;
    bit           hs;
    int           pick;
    #2;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      hs = m_busy && out_ready;
      if (!m_busy || hs) begin
        if (hs) begin
          m_ptr = (m_ch + 1) % M;
          cand  = req & ~(M'(1) << m_ch);
        end else begin
          cand = req;
        end
        if (cand != '0) begin
          pick = -1;
          for (int k = 0; k < M; k++) begin
            if (pick < 0 && cand[(m_ptr + k) % M]) pick = (m_ptr + k) % M;
          end
          exp_q.push_back('{ch: pick, data: ch_data[pick*N +: N]});
          m_busy = 1'b1;
          m_ch   = pick;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic set_fixed_data();
    for (int i = 0; i < M; i++) ch_data[i*N +: N] = N'(i + 1);
  endtask

  task automatic cyc(input logic [M-1:0] r, input logic rdy);
    @(negedge clk);
    req       = r;
    out_ready = rdy;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    set_fixed_data();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_select", 32'(select), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, then drain.
    cyc(8'b0000_0100, 1'b1);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);

    // Restart from ch1 priority, then full round robin.
    cyc(8'h00, 1'b0);
    rst = 1'b1;
    cyc(8'h00, 1'b0);
    rst = 1'b0;
    repeat (10) cyc(8'hFF, 1'b1);
    repeat (2) cyc(8'h00, 1'b1);

    // Backpressure on ch5 with its data changing and its request dropped.
    cyc(8'b0001_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 1'b0);
      ch_data[4*N +: N] = N'($urandom);
    end
    cyc(8'h00, 1'b1);
    set_fixed_data();
    cyc(8'h00, 1'b1);

    // Wrap: after ch8, ch1 is first, then ch8.
    cyc(8'b1000_0000, 1'b1);
    repeat (3) cyc(8'b1000_0001, 1'b1);
    repeat (2) cyc(8'h00, 1'b1);

    // Sole streamer.
    repeat (6) cyc(8'b0001_0000, 1'b1);
    cyc(8'h00, 1'b1);

    // Asynchronous reset while a transfer is held.
    cyc(8'hFF, 1'b0);
    cyc(8'hFF, 1'b0);
    #3;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_select", 32'(select), 32'h0);
    check("arst_data", 32'(out_data), 32'h0);
    check("arst_ack", 32'(in_ack), 32'h0);
    cyc(8'hFF, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req       = M'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      out_ready = ($urandom_range(0, 3) != 0);
      ch_data   = (M*N)'({$urandom, $urandom});
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc(8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
